// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared types and helpers for the key press conditioner
package key_cond_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD_DELAY,
    HELD_REPEAT,
    RELEASE_WAIT
  } key_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_press_conditioner.sv
// rtl/key_press_conditioner.sv - debounces a raw key and generates press, release and auto-repeat pulses
module key_press_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic resetN,
  input  logic key_raw,
  input  logic repeat_en,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic key_event
);

  localparam int CNT_BITS = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  localparam logic [CNT_BITS-1:0] DB_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] RD_LAST = CNT_BITS'(REPEAT_DELAY - 1);
  localparam logic [CNT_BITS-1:0] RP_LAST = CNT_BITS'(REPEAT_PERIOD - 1);

  logic                ks;
  key_state_t          state, state_n;
  logic [CNT_BITS-1:0] cnt, cnt_n;
  logic                level_n, press_n, release_n, repeat_n;

  sync_2ff u_sync (
    .clk    (clk),
    .resetN (resetN),
    .d      (key_raw),
    .q      (ks)
  );

  // Priority in every held state: key released, then repeat disabled, then terminal count.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = key_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      IDLE: begin
        level_n = 1'b0;
        if (ks) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!ks) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = HELD_DELAY;
          cnt_n   = '0;
          level_n = 1'b1;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD_DELAY: begin
        if (!ks) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end else if (!repeat_en) begin
          cnt_n = '0;
        end else if (cnt == RD_LAST) begin
          state_n  = HELD_REPEAT;
          cnt_n    = '0;
          repeat_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD_REPEAT: begin
        if (!ks) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end else if (!repeat_en) begin
          state_n = HELD_DELAY;
          cnt_n   = '0;
        end else if (cnt == RP_LAST) begin
          cnt_n    = '0;
          repeat_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A return to high here is contact bounce: resume holding and restart the repeat delay.
        if (ks) begin
          state_n = HELD_DELAY;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n   = IDLE;
          cnt_n     = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      cnt           <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      key_event     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      key_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      repeat_pulse  <= repeat_n;
      key_event     <= press_n | repeat_n;
    end
  end

endmodule
